lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between the execute stage and a variable-latency data-memory port.
//  Takes the decoded mem_read/mem_write/mem_funct3 controls and the ALU address, then:
//  checks alignment, drives a req/gnt + rvalid bus, builds byte enables, and formats load data.
//  Holds the pipeline (lsu_stall) while an access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in REQ+RSP before the access is abandoned (>=2, counter width = $clog2+1)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  ex_valid     in   1   execute stage holds a valid instruction
//  ex_mem_read  in   1   decoded load
//  ex_mem_write in   1   decoded store
//  ex_funct3    in   3   decoded mem_funct3 (size/sign)
//  ex_addr      in   32  effective address (rs1+imm)
//  ex_wdata     in   32  store data (rs2)
//  flush        in   1   kill in-flight access (branch/jump redirect)
//  lsu_stall    out  1   hold upstream stages
//  wb_valid     out  1   1-cycle pulse: load data valid on wb_rdata
//  wb_rdata     out  32  extended load result
//  fault        out  1   1-cycle pulse: access rejected/abandoned
//  fault_code   out  2   01 misaligned, 10 illegal funct3 or read&write, 11 bus timeout
//  dmem_req     out  1   bus request; held with addr/we/be/wdata stable until dmem_gnt
//  dmem_we      out  1   1=store
//  dmem_addr    out  32  word address {ex_addr[31:2],2'b00}
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_gnt     in   1   request accepted
//  dmem_rvalid  in   1   response (load data or store ack), earliest cycle after gnt
//  dmem_rdata   in   32  load word
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0, every output 0. Reset mid-access aborts at once (dmem_req drops).
//  FSM IDLE -> REQ -> RSP -> DONE -> IDLE.
//  IDLE/DONE accept when ex_valid & (ex_mem_read|ex_mem_write):
//   - Both read and write set, load funct3 in {011,110,111}, or store funct3 > 010: fault=1, code 10.
//   - Halfword with addr[0]!=0 or word with addr[1:0]!=0: fault=1, code 01.
//   - On fault: no bus request, lsu_stall=0, remain IDLE.
//   - Otherwise latch op/addr/data, go to REQ; lsu_stall=1 combinationally in the accept cycle.
//  REQ: dmem_req=1. On gnt -> RSP. flush before gnt -> IDLE (no bus effect).
//  RSP: wait for dmem_rvalid -> DONE. flush after gnt sets a kill flag; still wait for rvalid,
//   but suppress wb_valid.
//  DONE (1 cycle): lsu_stall=0. wb_valid=1 for an unkilled load, with wb_rdata registered from rvalid.
//   Stores give wb_valid=0. A new access may be accepted in DONE.
//  lsu_stall = accept-in-IDLE/DONE | state in {REQ,RSP}.
//  Timeout: counter clears on accept and increments each cycle in REQ/RSP.
//   When it reaches TIMEOUT_CYCLES-1: fault=1, code 11, go to IDLE, no wb_valid.
//   A late rvalid in IDLE is ignored.
//  Stores:
//   - SB: be=4'b0001<<addr[1:0], wdata={4{b}}.
//   - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{h}}.
//   - SW: be=4'hF.
//  Loads: be=4'hF. Select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  wb_rdata holds its last value when wb_valid=0.
// TESTING
//  LW 0x100, gnt next cycle, rvalid+2 with 0xDEADBEEF -> stall 4 cycles, wb_valid once, wb_rdata=0xDEADBEEF.
//  LB addr 0x103, rdata 0x80xxxxxx -> wb_rdata=0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x202, wdata 0x1234 -> be=1100, dmem_wdata=0x12341234, no wb_valid.
//  LW addr 0x101 -> fault=1 code 01 in 1 cycle, dmem_req never set, stall 0.
//  gnt never given, TIMEOUT_CYCLES=8 -> fault code 11 after 8 stalled cycles, FSM IDLE.
//  flush in RSP, then rvalid -> no wb_valid. rst_n low in REQ -> dmem_req=0 immediately.

Source files
------------

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_ctrl : load/store sequencer between execute and a req/gnt/rvalid     |
// |            data-memory port (alignment, byte enables, load formatting).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        flush,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int               c_cnt_w   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_rsp  = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [1:0] c_fc_misal   = 2'b01;
  localparam logic [1:0] c_fc_illegal = 2'b10;
  localparam logic [1:0] c_fc_timeout = 2'b11;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_kill;
  logic               r_load;
  logic [2:0]         r_f3;
  logic [1:0]         r_lane;
  logic               r_wb_valid;
  logic [31:0]        r_wb_rdata;
  logic               r_fault;
  logic [1:0]         r_fault_code;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;

  logic        w_op;
  logic        w_illegal;
  logic        w_misal;
  logic        w_try;
  logic        w_accept;
  logic        w_req_fault;
  logic        w_busy;
  logic        w_timeout;
  logic        w_wb_fire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_fmt;

  // Decode and qualify the access presented by execute
  assign w_op      = ex_valid & (ex_mem_read | ex_mem_write);
  assign w_illegal = (ex_mem_read & ex_mem_write)
                   | (ex_mem_read & ((ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) |
                                     (ex_funct3 == 3'b111)))
                   | (ex_mem_write & (ex_funct3 > 3'b010));
  assign w_misal   = ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
                   | ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
  assign w_try       = ((r_state == c_st_idle) | (r_state == c_st_done)) & w_op;
  assign w_accept    = w_try & ~w_illegal & ~w_misal;
  assign w_req_fault = w_try & (w_illegal | w_misal);
  assign w_busy      = (r_state == c_st_req) | (r_state == c_st_rsp);
  assign w_timeout   = w_busy & (r_cnt == c_cnt_max);
  assign w_wb_fire   = (r_state == c_st_rsp) & dmem_rvalid & ~w_timeout &
                       r_load & ~r_kill & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: w_state_nxt = w_accept ? c_st_req : c_st_idle;
      c_st_req: begin
        if (w_timeout)     w_state_nxt = c_st_idle;
        else if (dmem_gnt) w_state_nxt = c_st_rsp;
        else if (flush)    w_state_nxt = c_st_idle;
      end
      c_st_rsp: begin
        if (w_timeout)        w_state_nxt = c_st_idle;
        else if (dmem_rvalid) w_state_nxt = c_st_done;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    lsu_stall = w_accept | w_busy;
    dmem_req  = (r_state == c_st_req);
  end

  always_comb begin
    w_be    = 4'hF;
    w_wdata = ex_wdata;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ex_addr[1:0];
          w_wdata = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {ex_addr[1], 1'b0};
          w_wdata = {2{ex_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'hF;
          w_wdata = ex_wdata;
        end
      endcase
    end
  end

  // Halfwords are aligned, so shifting by the byte lane also selects the half lane
  assign w_lane_half = 16'(dmem_rdata >> {r_lane, 3'b000});

  always_comb begin
    w_load_fmt = dmem_rdata;
    case (r_f3)
      3'b000:  w_load_fmt = {{24{w_lane_half[7]}}, w_lane_half[7:0]};
      3'b001:  w_load_fmt = {{16{w_lane_half[15]}}, w_lane_half};
      3'b100:  w_load_fmt = {24'd0, w_lane_half[7:0]};
      3'b101:  w_load_fmt = {16'd0, w_lane_half};
      default: w_load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_kill       <= 1'b0;
      r_load       <= 1'b0;
      r_f3         <= 3'd0;
      r_lane       <= 2'd0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_wb_valid   <= 1'b0;
      r_wb_rdata   <= 32'd0;
    end else begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_wb_valid   <= w_wb_fire;

      if (w_accept) begin
        r_cnt   <= '0;
        r_kill  <= 1'b0;
        r_load  <= ex_mem_read;
        r_f3    <= ex_funct3;
        r_lane  <= ex_addr[1:0];
        r_we    <= ex_mem_write;
        r_addr  <= {ex_addr[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A flush once the bus has taken the request cannot recall it; only the writeback dies
      if (flush & (((r_state == c_st_req) & dmem_gnt) | (r_state == c_st_rsp))) begin
        r_kill <= 1'b1;
      end

      if (w_req_fault) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_illegal ? c_fc_illegal : c_fc_misal;
      end else if (w_timeout) begin
        r_fault      <= 1'b1;
        r_fault_code <= c_fc_timeout;
      end

      if (w_wb_fire) begin
        r_wb_rdata <= w_load_fmt;
      end
    end
  end

  assign wb_valid   = r_wb_valid;
  assign wb_rdata   = r_wb_rdata;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_ctrl : directed and randomized self-checking bench for lsu_ctrl.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_lsu_ctrl;

  localparam int c_timeout = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        flush;
  logic        lsu_stall, wb_valid, fault;
  logic [31:0] wb_rdata;
  logic [1:0]  fault_code;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_wb = 32'd0;

  lsu_ctrl #(.TIMEOUT_CYCLES(c_timeout)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
    .lsu_stall(lsu_stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
    .fault(fault), .fault_code(fault_code),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference rules, expressed in access sizes and byte arithmetic
  function automatic logic [1:0] ref_fault(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    if (rd && wr) return 2'b10;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b10;
    if (wr && f3 > 3'd2) return 2'b10;
    sz = 1 << f3[1:0];
    if (a % sz != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] ref_be(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a);
    int unsigned sz;
    if (!wr) return 4'hF;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[7:0];
    h = w[15:0];
    if (f3 == 3'd0) return {b, b, b, b};
    if (f3 == 3'd1) return {h, h};
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    case (f3)
      3'd0: return (v & 32'hFF) >= 32'h80 ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
      3'd1: return (v & 32'hFFFF) >= 32'h8000 ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      3'd4: return v & 32'hFF;
      3'd5: return v & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  // One complete access starting from IDLE; gdly = REQ cycles before gnt, rdly = RSP cycles before rvalid
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rdat,
                        input logic fl);
    logic [1:0] code;
    int         stalls;
    logic       exp_wb;
    code   = ref_fault(rd, wr, f3, a);
    stalls = 0;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
    #1;
    check("accept_stall", 32'(lsu_stall), 32'(code == 2'b00));
    if (lsu_stall) stalls++;
    tick;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    #1;
    if (code != 2'b00) begin
      check("fault", 32'(fault), 32'd1);
      check("fault_code", 32'(fault_code), 32'(code));
      check("fault_no_req", 32'(dmem_req), 32'd0);
      check("fault_stall", 32'(lsu_stall), 32'd0);
      tick;
      check("fault_pulse", 32'(fault), 32'd0);
      return;
    end
    for (int i = 0; i <= gdly; i++) begin
      check("req", 32'(dmem_req), 32'd1);
      check("addr", dmem_addr, a & 32'hFFFF_FFFC);
      check("we", 32'(dmem_we), 32'(wr));
      check("be", 32'(dmem_be), 32'(ref_be(wr, f3, a)));
      if (wr) check("wdata", dmem_wdata, ref_wdata(f3, wd));
      if (lsu_stall) stalls++;
      dmem_gnt = (i == gdly);
      tick;
      dmem_gnt = 1'b0;
    end
    for (int j = 0; j <= rdly; j++) begin
      check("rsp_req", 32'(dmem_req), 32'd0);
      if (lsu_stall) stalls++;
      flush       = fl && (j == 0);
      dmem_rvalid = (j == rdly);
      dmem_rdata  = (j == rdly) ? rdat : $urandom;
      tick;
      flush = 1'b0; dmem_rvalid = 1'b0;
    end
    exp_wb = rd && !fl;
    if (exp_wb) last_wb = ref_load(f3, a, rdat);
    check("wb_valid", 32'(wb_valid), 32'(exp_wb));
    check("wb_rdata", wb_rdata, last_wb);
    check("done_stall", 32'(lsu_stall), 32'd0);
    check("done_fault", 32'(fault), 32'd0);
    check("stall_cycles", 32'(stalls), 32'(gdly + rdly + 3));
    tick;
    check("wb_pulse", 32'(wb_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; flush = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(lsu_stall), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_wb", 32'(wb_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    rst_n = 1'b1;
    tick;

    // Directed cases from the block's feature list
    access(1, 0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEAD_BEEF, 0);
    access(1, 0, 3'b000, 32'h103, 32'd0, 1, 0, 32'h80AB_CDEF, 0);
    access(1, 0, 3'b100, 32'h103, 32'd0, 0, 0, 32'h80AB_CDEF, 0);
    access(1, 0, 3'b001, 32'h102, 32'd0, 0, 2, 32'h9876_0000, 0);
    access(1, 0, 3'b101, 32'h102, 32'd0, 2, 0, 32'h9876_0000, 0);
    access(0, 1, 3'b001, 32'h202, 32'h0000_1234, 0, 0, 32'd0, 0);
    access(0, 1, 3'b000, 32'h301, 32'hCAFE_F0A5, 1, 1, 32'd0, 0);
    access(1, 0, 3'b010, 32'h101, 32'd0, 0, 0, 32'd0, 0);
    access(1, 0, 3'b001, 32'h105, 32'd0, 0, 0, 32'd0, 0);
    access(1, 1, 3'b010, 32'h100, 32'd0, 0, 0, 32'd0, 0);
    access(1, 0, 3'b011, 32'h100, 32'd0, 0, 0, 32'd0, 0);
    access(0, 1, 3'b100, 32'h100, 32'd0, 0, 0, 32'd0, 0);
    access(1, 0, 3'b010, 32'h400, 32'd0, 0, 1, 32'h1357_9BDF, 1);

    // Bus never grants: abandoned after c_timeout cycles in REQ
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h40;
    tick;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    n = 0;
    while (dmem_req === 1'b1 && n < 4 * c_timeout) begin
      n++;
      tick;
    end
    check("timeout_cycles", 32'(n), 32'(c_timeout));
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_code", 32'(fault_code), 32'd3);
    check("timeout_stall", 32'(lsu_stall), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick;
    dmem_rvalid = 1'b0;
    check("late_rvalid", 32'(wb_valid), 32'd0);
    check("late_rdata", wb_rdata, last_wb);

    // Flush before grant drops the request
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h80;
    tick;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    check("flreq_req", 32'(dmem_req), 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flreq_drop", 32'(dmem_req), 32'd0);
    check("flreq_stall", 32'(lsu_stall), 32'd0);
    tick;
    check("flreq_wb", 32'(wb_valid), 32'd0);

    // Reset while requesting aborts immediately
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h90;
    tick;
    ex_valid = 1'b0; ex_mem_write = 1'b0;
    check("rstreq_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstreq_drop", 32'(dmem_req), 32'd0);
    check("rstreq_stall", 32'(lsu_stall), 32'd0);
    check("rstreq_be", 32'(dmem_be), 32'd0);
    #2;
    rst_n = 1'b1;
    last_wb = 32'd0;
    tick;

    // Randomized accesses against the reference rules
    for (int k = 0; k < 150; k++) begin
      int unsigned op;
      op = $urandom_range(1, 3);
      access(op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom,
             ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
